// File: rtl/uram_stream_reader_pkg.sv
// Shared types and helpers for the URAM stream reader.
//   state_t      : sequencer state encoding (IDLE / RUN / DRAIN)
//   bit_reverse  : reverses the low 'width' bits of a value (width <= 32)
package uram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Reverse all 32 bits, then shift the reversed window down so that
    // value[0] lands on bit width-1.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31-i];
        end
        return rev >> (32 - width);
    endfunction

endpackage

// File: rtl/uram_stream_reader_fifo.sv
// stream_skid_fifo2: two-entry FIFO used as the output skid buffer.
//   clk, rst_n  : clock, asynchronous active-low reset (clears storage too)
//   push        : write push_data this cycle
//   push_data   : entry to store
//   pop         : remove head entry this cycle (ignored when empty)
//   head_data   : current head entry
//   empty       : no entries held
//   count       : number of entries held (0..2)
// Push and pop in the same cycle are both honoured. The producer guarantees
// that a push never happens into a full FIFO without a simultaneous pop.
module stream_skid_fifo2 #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             pop_ok;

    assign pop_ok = pop & (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign head_data = slot[rd_ptr];
    assign empty     = (cnt == 2'd0);
    assign count     = cnt;

endmodule

// File: rtl/uram_stream_reader.sv
// uram_stream_reader: read-side sequencer for one single-port URAM bank.
// On start it reads len words at base + i*stride (optionally bit-reversed)
// and delivers them as a valid/ready stream with full backpressure.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : command strobe, accepted only while idle
//   base, stride, len    : run description (index arithmetic wraps)
//   bitrev               : address = bit-reverse(index)
//   busy, done           : run in progress / one-cycle completion pulse
//   mem_addr, mem_we,
//   mem_din, mem_rdata   : bank port (write side held idle, 1-cycle read)
//   out_data, out_valid,
//   out_last, out_ready  : output stream
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start; len==0 just pulses done
// ST_RUN   | issuing addresses, throttled by the skid buffer space
// ST_DRAIN | all addresses issued; waiting for the last transfer
module uram_stream_reader
    import uram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  bitrev,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  popped;
    logic                  bitrev_q;
    logic                  inflight;
    logic                  inflight_last;
    logic                  issue;
    logic                  issue_is_last;
    logic                  pop;
    logic                  fifo_empty;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH:0]   head;

    // Entries already buffered or on their way, after this cycle's pop.
    // Never negative: pop requires a non-empty buffer.
    assign occupancy     = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue_addr    = bitrev_q ? ADDR_WIDTH'(bit_reverse(32'(idx), ADDR_WIDTH)) : idx;
    assign issue_is_last = (issued == len_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = (occupancy < 3'd2);
                if (issue && issue_is_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (popped == len_q - ONE)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            stride_q      <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            issued        <= '0;
            popped        <= '0;
            bitrev_q      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                if (len == '0) begin
                    done <= 1'b1;
                end else begin
                    idx      <= base;
                    stride_q <= stride;
                    len_q    <= len;
                    bitrev_q <= bitrev;
                    issued   <= '0;
                    popped   <= '0;
                end
            end
            if ((state == ST_DRAIN) && (state_nxt == ST_IDLE)) begin
                done <= 1'b1;
            end
            if (issue) begin
                addr_q <= issue_addr;
                idx    <= idx + stride_q;
                issued <= issued + ONE;
            end
            if (pop) begin
                popped <= popped + ONE;
            end
            inflight      <= issue;
            inflight_last <= issue & issue_is_last;
        end
    end

    // The address is driven combinationally in the issue cycle so the bank
    // registers it on the same edge; otherwise the last address is held.
    assign mem_addr = issue ? issue_addr : addr_q;
    assign mem_we   = 1'b0;
    assign mem_din  = '0;
    assign busy     = (state != ST_IDLE);

    stream_skid_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data({inflight_last, mem_rdata}),
        .pop      (pop),
        .head_data(head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = out_valid & head[DATA_WIDTH];
    assign pop       = out_valid & out_ready;

endmodule

// File: tb/tb_uram_stream_reader.sv
module tb_uram_stream_reader;

    localparam int DW = 72;
    localparam int AW = 12;
    localparam int LW = 13;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_i;
    logic [AW-1:0] stride_i;
    logic [LW-1:0] len_i;
    logic          bitrev_i;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    logic [DW-1:0] ram [0:DEPTH-1];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    uram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base_i),
        .stride   (stride_i),
        .len      (len_i),
        .bitrev   (bitrev_i),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_rdata(mem_rdata),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    // Behavioural uram_unit: registered read, write port ignored unless enabled.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [DW-1:0] ram_word(input int a);
        return {4'hC, 24'(a * 40503), 32'(a ^ 32'h5A5A), 12'(a)};
    endfunction

    // Reference: address of element k from plain modular arithmetic.
    function automatic int ref_addr(input int base, input int stride, input int k, input bit br);
        int a;
        int r;
        a = (base + k * stride) % DEPTH;
        if (!br) return a;
        r = 0;
        for (int b = 0; b < AW; b++) begin
            if (((a >> b) & 1) == 1) r = r + (1 << (AW - 1 - b));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic run_stream(input int base, input int stride, input int len, input bit br,
                              input int mode, input bit inject, input bit timing,
                              output int first_tag, output int last_tag);
        int  got = 0;
        int  first_valid = -1;
        int  done_cyc = -1;
        int  last_xfer = -1;
        int  done_cnt = 0;
        int  budget;
        bit  prev_stall = 1'b0;
        logic [DW:0] prev = '0;
        first_tag = -1;
        last_tag  = -1;
        budget = len * 8 + 60;
        @(negedge clk);
        start    = 1'b1;
        base_i   = AW'(base);
        stride_i = AW'(stride);
        len_i    = LW'(len);
        bitrev_i = br;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (inject && cyc == 5) begin
                start    = 1'b1;
                base_i   = 12'd100;
                stride_i = 12'd9;
                len_i    = 13'd3;
                bitrev_i = ~br;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == 1) check("busy_after_start", DW'(busy), DW'(1));
            if (prev_stall) begin
                check("stall_valid", DW'(out_valid), DW'(1));
                check("stall_data", DW'({out_last, out_data}), DW'(prev));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (got < len) begin
                    check("data", out_data, ram_word(ref_addr(base, stride, got, br)));
                    check("last", DW'(out_last), DW'(got == len - 1));
                end else begin
                    check("extra_output", DW'(got), DW'(len - 1));
                end
                if (got == 0) first_tag = int'(out_data[11:0]);
                last_tag  = int'(out_data[11:0]);
                got++;
                last_xfer = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev       = {out_last, out_data};
            if (done_cyc >= 0 && cyc > done_cyc + 2) break;
        end
        check("count", DW'(got), DW'(len));
        check("done_once", DW'(done_cnt), DW'(1));
        check("done_timing", DW'(done_cyc), DW'(last_xfer + 1));
        check("idle_after", DW'(busy), DW'(0));
        if (timing) begin
            check("first_valid_cycle", DW'(first_valid), DW'(3));
            check("done_cycle", DW'(done_cyc), DW'(len + 3));
        end
    endtask

    typedef struct {
        int base;
        int stride;
        int len;
        bit br;
        int mode;
        bit inject;
        bit timing;
        int exp_a0;
        int exp_alast;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ft;
        int lt;
        int cnt;
        bit done_seen;

        vecs[0] = '{0,    1, 8,    0, 0, 0, 1, 0,    7};
        vecs[1] = '{4090, 3, 4,    0, 0, 0, 1, 4090, 3};
        vecs[2] = '{1,    1, 3,    1, 0, 0, 1, 2048, 3072};
        vecs[3] = '{0,    1, 16,   0, 1, 1, 0, 0,    15};
        vecs[4] = '{100,  7, 12,   1, 2, 1, 0, 608,  2256};
        vecs[5] = '{4095, 1, 2,    0, 0, 0, 1, 4095, 0};
        vecs[6] = '{0,    5, 4,    1, 1, 0, 0, 0,    3840};
        vecs[7] = '{7,    5, 4096, 0, 0, 0, 1, 7,    2};

        for (int i = 0; i < DEPTH; i++) ram[i] = ram_word(i);

        rst_n = 1'b0; start = 1'b0; base_i = '0; stride_i = '0; len_i = '0;
        bitrev_i = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_valid", DW'(out_valid), DW'(0));
        check("rst_last", DW'(out_last), DW'(0));
        check("rst_addr", DW'(mem_addr), DW'(0));
        check("rst_data", out_data, '0);
        check("mem_we", DW'(mem_we), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_stream(vecs[v].base, vecs[v].stride, vecs[v].len, vecs[v].br,
                       vecs[v].mode, vecs[v].inject, vecs[v].timing, ft, lt);
            check("first_addr", DW'(ft), DW'(vecs[v].exp_a0));
            check("last_addr", DW'(lt), DW'(vecs[v].exp_alast));
        end

        // Randomised runs against the reference model.
        for (int r = 0; r < 10; r++) begin
            int ln;
            ln = int'($urandom_range(1, 40));
            run_stream(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), ln,
                       1'($urandom_range(0, 1)), 2, (ln >= 8), 0, ft, lt);
        end

        // len == 0: done pulse only.
        @(negedge clk);
        start = 1'b1; len_i = '0; base_i = 12'd5; stride_i = 12'd1;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", DW'(done), DW'(1));
        check("len0_busy", DW'(busy), DW'(0));
        check("len0_valid", DW'(out_valid), DW'(0));
        @(negedge clk);
        check("len0_done_fall", DW'(done), DW'(0));
        check("len0_valid2", DW'(out_valid), DW'(0));

        // Reset in the middle of a run after three outputs.
        out_ready = 1'b1;
        start = 1'b1; base_i = '0; stride_i = 12'd1; len_i = 13'd16; bitrev_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30 && cnt < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_ready) cnt++;
        end
        check("pre_reset_outputs", DW'(cnt), DW'(3));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", DW'(out_valid), DW'(0));
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_data", out_data, '0);
        check("mid_rst_last", DW'(out_last), DW'(0));
        done_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("no_done_after_reset", DW'(done_seen), DW'(0));
        run_stream(0, 1, 8, 1'b0, 0, 1'b0, 1'b1, ft, lt);
        check("post_reset_first", DW'(ft), DW'(0));
        check("post_reset_last", DW'(lt), DW'(7));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
